// File: rtl/reflet_ram_dp.sv
// True dual-port RAM with a sequential clear engine, registered read gating and A-priority write collisions.
// Optional macro REFLET_RAM_WRITE_FIRST_EN: reads coinciding with a same-address write return the new data.
module reflet_ram_dp #(
  parameter int addrSize  = 7,
  parameter int wordsize  = 8,
  parameter int size      = 128,
  parameter int resetable = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  output logic                ready,
  input  logic                a_enable,
  input  logic [addrSize-1:0] a_addr,
  input  logic                a_write_en,
  input  logic [wordsize-1:0] a_data_in,
  output logic [wordsize-1:0] a_data_out,
  input  logic                b_enable,
  input  logic [addrSize-1:0] b_addr,
  input  logic                b_write_en,
  input  logic [wordsize-1:0] b_data_in,
  output logic [wordsize-1:0] b_data_out
);

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size - 1);
  localparam logic [addrSize:0] SIZE_EXT = (addrSize + 1)'(size);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    cnt, cnt_next;
  logic                ready_next;
  logic                clr_we;

  logic [wordsize-1:0] mem [size];

  logic                usable_a, usable_b;
  logic                a_wr, b_wr;
  logic [IDX_W-1:0]    a_idx, b_idx;
  logic [wordsize-1:0] a_rd, b_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= (resetable != 0) ? ST_CLEAR : ST_READY;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= ready_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready_next = ready;
    clr_we     = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we   = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          state_next = ST_READY;
          cnt_next   = '0;
          ready_next = 1'b1;
        end
      end
      ST_READY: begin
        ready_next = 1'b1;
        if (clear_req && (resetable != 0)) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
          ready_next = 1'b0;
        end
      end
      default: state_next = ST_READY;
    endcase
  end

  // Addresses at or beyond size never reach the array, so index truncation cannot alias.
  assign usable_a = ready && a_enable && ({1'b0, a_addr} < SIZE_EXT);
  assign usable_b = ready && b_enable && ({1'b0, b_addr} < SIZE_EXT);
  assign a_idx    = a_addr[IDX_W-1:0];
  assign b_idx    = b_addr[IDX_W-1:0];
  assign a_wr     = usable_a && a_write_en;
  assign b_wr     = usable_b && b_write_en && !(a_wr && (a_addr == b_addr));

  always_comb begin
    a_rd = mem[a_idx];
    b_rd = mem[b_idx];
`ifdef REFLET_RAM_WRITE_FIRST_EN
    if (a_wr) begin
      a_rd = a_data_in;
    end else if (b_wr && (b_addr == a_addr)) begin
      a_rd = b_data_in;
    end
    if (a_wr && (a_addr == b_addr)) begin
      b_rd = a_data_in;
    end else if (b_wr) begin
      b_rd = b_data_in;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end
    if (b_wr) begin
      mem[b_idx] <= b_data_in;
    end
    if (a_wr) begin
      mem[a_idx] <= a_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_data_out <= '0;
      b_data_out <= '0;
    end else begin
      a_data_out <= usable_a ? a_rd : '0;
      b_data_out <= usable_b ? b_rd : '0;
    end
  end

endmodule

// File: tb/tb_reflet_ram_dp.sv
// Bench for reflet_ram_dp (addrSize=5, size=16): directed vectors, literal checks and a per-cycle behavioural model.
module tb_reflet_ram_dp;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int SZ = 16;

`ifdef REFLET_RAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_req = 1'b0;
  logic          ready;
  logic          a_enable = 1'b0, a_write_en = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data_in = '0, a_data_out;
  logic          b_enable = 1'b0, b_write_en = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data_in = '0, b_data_out;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  reflet_ram_dp #(.addrSize(AW), .wordsize(DW), .size(SZ), .resetable(1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
    .a_enable(a_enable), .a_addr(a_addr), .a_write_en(a_write_en),
    .a_data_in(a_data_in), .a_data_out(a_data_out),
    .b_enable(b_enable), .b_addr(b_addr), .b_write_en(b_write_en),
    .b_data_in(b_data_in), .b_data_out(b_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory array plus "words left to clear" bookkeeping.
  logic [DW-1:0] m_mem [SZ];
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  bit            m_clearing = 1'b1;
  int            m_clr_idx = 0;
  bit            ua, ub, wa, wb;
  logic [DW-1:0] ra, rb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clearing = 1'b1;
      m_clr_idx  = 0;
      m_ready    = 1'b0;
      m_a        = '0;
      m_b        = '0;
    end else begin
      ua = m_ready && a_enable && (int'(a_addr) < SZ);
      ub = m_ready && b_enable && (int'(b_addr) < SZ);
      wa = ua && a_write_en;
      wb = ub && b_write_en && !(wa && a_addr == b_addr);
      ra = ua ? m_mem[a_addr[3:0]] : '0;
      rb = ub ? m_mem[b_addr[3:0]] : '0;
      if (WF) begin
        if (wa) ra = a_data_in;
        else if (ua && wb && b_addr == a_addr) ra = b_data_in;
        if (ub && wa && a_addr == b_addr) rb = a_data_in;
        else if (wb) rb = b_data_in;
      end
      m_a = ra;
      m_b = rb;
      if (wb) m_mem[b_addr[3:0]] = b_data_in;
      if (wa) m_mem[a_addr[3:0]] = a_data_in;
      if (m_clearing) begin
        m_mem[m_clr_idx] = '0;
        m_clr_idx++;
        if (m_clr_idx == SZ) begin
          m_clearing = 1'b0;
          m_ready    = 1'b1;
        end
      end else if (clear_req) begin
        m_clearing = 1'b1;
        m_clr_idx  = 0;
        m_ready    = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      n_cmp++;
      if (ready !== m_ready || a_data_out !== m_a || b_data_out !== m_b) begin
        n_err++;
        $display("FAIL model_cmp t=%0t ready got %b exp %b, a got %h exp %h, b got %h exp %h",
                 $time, ready, m_ready, a_data_out, m_a, b_data_out, m_b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    a_enable = 0; a_write_en = 0; a_addr = '0; a_data_in = '0;
    b_enable = 0; b_write_en = 0; b_addr = '0; b_data_in = '0;
    clear_req = 0;
  endtask

  task automatic port_a(input logic en, input logic we, input int addr, input logic [DW-1:0] d);
    a_enable = en; a_write_en = we; a_addr = AW'(addr); a_data_in = d;
  endtask

  task automatic port_b(input logic en, input logic we, input int addr, input logic [DW-1:0] d);
    b_enable = en; b_write_en = we; b_addr = AW'(addr); b_data_in = d;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ready && n < 40);
  endtask

  initial begin
    int n;
    cmp_on = 1'b1;
    idle();
    repeat (3) step();
    chk("reset_ready", ready, 0);
    chk("reset_a", a_data_out, 0);
    chk("reset_b", b_data_out, 0);
    reset = 1'b0;
    wait_ready(n);
    chk("ready_latency_initial", n, 16);

    for (int i = 0; i < SZ; i++) begin
      port_a(1, 0, i, 0);
      port_b(1, 0, SZ - 1 - i, 0);
      step();
      chk("init_zero_a", a_data_out, 0);
      chk("init_zero_b", b_data_out, 0);
    end

    idle(); port_a(1, 1, 5, 8'hA5); step();
    idle(); port_b(1, 0, 5, 0); step();
    chk("basic_b_read", b_data_out, 8'hA5);
    idle(); step();
    chk("b_disabled_zero", b_data_out, 0);

    port_a(1, 1, 3, 8'h11); port_b(1, 1, 3, 8'h22); step();
    chk("collision_a_out", a_data_out, WF ? 8'h11 : 8'h00);
    chk("collision_b_out", b_data_out, WF ? 8'h11 : 8'h00);
    idle(); port_a(1, 0, 3, 0); step();
    chk("collision_stored", a_data_out, 8'h11);

    idle(); port_a(1, 1, 7, 8'h10); step();
    port_a(1, 1, 7, 8'h33); port_b(1, 0, 7, 0); step();
    chk("rdw_cross_b", b_data_out, WF ? 8'h33 : 8'h10);
    chk("rdw_same_a", a_data_out, WF ? 8'h33 : 8'h10);
    idle(); port_b(1, 0, 7, 0); step();
    chk("rdw_after", b_data_out, 8'h33);

    idle(); port_b(1, 1, 4, 8'h44); step();
    idle(); port_a(1, 1, 20, 8'hFF); step();
    idle(); port_a(1, 0, 20, 0); port_b(1, 0, 4, 0); step();
    chk("oor_read", a_data_out, 0);
    chk("oor_no_alias", b_data_out, 8'h44);

    reset = 1'b1;
    #1;
    chk("async_reset_ready", ready, 0);
    chk("async_reset_b", b_data_out, 0);
    idle(); step();
    reset = 1'b0;
    wait_ready(n);
    chk("ready_latency_midrun", n, 16);

    for (int i = 0; i < SZ / 2; i++) begin
      port_a(1, 1, 2 * i, 8'h5A);
      port_b(1, 1, 2 * i + 1, 8'h5A);
      step();
    end
    idle(); port_a(1, 0, 9, 0); step();
    chk("fill_read", a_data_out, 8'h5A);
    idle(); clear_req = 1'b1; step();
    clear_req = 1'b0;
    chk("clear_ready_drop", ready, 0);
    for (int k = 0; k < 7; k++) begin
      port_a(1, 1, 2, 8'h77); port_b(1, 0, 2, 0); step();
      chk("clear_read_zero", b_data_out, 0);
    end
    reset = 1'b1;
    #1;
    chk("reset_in_clear_ready", ready, 0);
    idle(); step(); step();
    reset = 1'b0;
    n = 0;
    do begin
      clear_req = (n == 5);
      step();
      n++;
    end while (!ready && n < 40);
    clear_req = 1'b0;
    chk("ready_latency_after_clear_reset", n, 16);
    for (int i = 0; i < SZ; i++) begin
      port_a(1, 0, i, 0); port_b(1, 0, i, 0); step();
      chk("cleared_a", a_data_out, 0);
      chk("cleared_b", b_data_out, 0);
    end

    idle(); port_a(1, 1, 9, 8'h99); step();
    idle(); clear_req = 1'b1; step();
    clear_req = 1'b0;
    wait_ready(n);
    chk("ready_latency_clear_req", n, 16);
    port_a(1, 0, 9, 0); step();
    chk("clear_req_zeroed", a_data_out, 0);

    idle(); step();
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
